// File: rtl/tx_frame_arbiter_pkg.sv
// Shared types and width helpers for the transmit frame arbiter.
// Optional watchdog is enabled by defining TX_ARB_WATCHDOG_EN.
package tx_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Bits needed to hold the values 0 .. v-1 (never less than one bit).
    function automatic int width_of(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// Round-robin picker: one-hot of the first set request at or above ptr, with wrap.
module tx_frame_arbiter_rr_pick
    import tx_frame_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = width_of(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one paced word channel, with inter-frame gap.
// Define TX_ARB_WATCHDOG_EN to abort frames that stall for TIMEOUT cycles.
module tx_frame_arbiter
    import tx_frame_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int WORD_PERIOD = 4,
    parameter int IFG_CYCLES  = 48,
    parameter int TIMEOUT     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]            last_in,
    input  logic                          out_rdy,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic                          out_abort,
    output logic                          busy,
    output logic [1:0]                    state_dbg
);

    localparam int PTR_W = width_of(NUM_REQ);
    localparam int CNT_W = width_of(WORD_PERIOD);
    localparam int GAP_W = width_of(IFG_CYCLES);

    arb_state_e             state, state_n;
    logic [NUM_REQ-1:0]     grant_n, pick;
    logic                   pick_any;
    logic [PTR_W-1:0]       ptr, ptr_n, g_idx, ptr_adv;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [GAP_W-1:0]       gap_cnt, gap_n;
    logic                   out_valid_n, out_last_n, out_abort_n;
    logic [DATA_WIDTH-1:0]  out_data_n, sel_data;
    logic                   sel_last, req_g, tick, xfer, wd_fire;

    tx_frame_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (pick_any)
    );

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        g_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last = last_in[i];
                g_idx    = PTR_W'(i);
            end
        end
    end

    // Handshake: a word moves in a cycle where the pace slot is open (cnt==0), out_rdy is
    // high and the owner's req is high; ack marks that cycle, out_valid follows one cycle later.
    assign req_g   = |(req & grant);
    assign tick    = (cnt == '0);
    assign xfer    = (state == ST_BUSY) && tick && out_rdy && req_g;
    assign ptr_adv = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);

`ifdef TX_ARB_WATCHDOG_EN
    localparam int STALL_W = width_of(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_BUSY || xfer) begin
            stall_cnt <= '0;
        end else if (!wd_fire) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    assign wd_fire = (state == ST_BUSY) && (stall_cnt == STALL_W'(TIMEOUT));
`else
    // TIMEOUT only matters when the watchdog is built in.
    assign wd_fire = (TIMEOUT < 0);
`endif

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        ptr_n       = ptr;
        cnt_n       = cnt;
        gap_n       = gap_cnt;
        out_valid_n = 1'b0;
        out_data_n  = out_data;
        out_last_n  = 1'b0;
        out_abort_n = 1'b0;
        ack         = '0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_n = pick;
                    cnt_n   = '0;
                    state_n = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // After a transfer the counter runs 1..WORD_PERIOD-1 then rests at 0 until used.
                if (!tick) begin
                    cnt_n = (cnt == CNT_W'(WORD_PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
                end
                if (xfer) begin
                    ack         = grant;
                    out_valid_n = 1'b1;
                    out_data_n  = sel_data;
                    out_last_n  = sel_last;
                    cnt_n       = (WORD_PERIOD == 1) ? '0 : CNT_W'(1);
                end else if (!req_g || wd_fire) begin
                    out_abort_n = 1'b1;
                end
                if ((xfer && sel_last) || out_abort_n) begin
                    ptr_n   = ptr_adv;
                    grant_n = '0;
                    if (IFG_CYCLES == 0) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_GAP;
                        gap_n   = GAP_W'(IFG_CYCLES - 1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_abort <= 1'b0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            gap_cnt   <= gap_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_last  <= out_last_n;
            out_abort <= out_abort_n;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: vector table, directed corner sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_tx_frame_arbiter;

    localparam int N   = 2;
    localparam int DW  = 8;
    localparam int WP  = 4;
    localparam int IFG = 6;
    localparam int TO  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    last_in;
    logic            out_rdy;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_abort;
    logic            busy;
    logic [1:0]      state_dbg;

    tx_frame_arbiter #(
        .NUM_REQ     (N),
        .DATA_WIDTH  (DW),
        .WORD_PERIOD (WP),
        .IFG_CYCLES  (IFG),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .last_in   (last_in),
        .out_rdy   (out_rdy),
        .ack       (ack),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_abort (out_abort),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves time at a negedge with rst low: the following cycle is the first IDLE cycle.
    task automatic reset_dut();
        rst     = 1'b1;
        req     = '0;
        last_in = '0;
        data_in = '0;
        out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_grant", grant, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_last", out_last, 0);
        chk("reset_abort", out_abort, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ack", ack, 0);
        chk("reset_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Samples at +1 after the current negedge; returns at the sample point of the ack cycle.
    task automatic wait_ack(input logic [N-1:0] m, input int limit, input string name);
        int n = 0;
        #1;
        while (((ack & m) == '0) && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, ack & m, m);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]  req;
        logic [DW-1:0] d0;
        logic [N-1:0]  last;
        logic          rdy;
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_ack;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_last;
        logic          e_busy;
    } vec_t;

    vec_t vecs[17];

    // ---------------- reference model + scoreboard ----------------
    int              cyc;
    int              m_owner, m_ptr, m_free_at, m_next_slot;
    logic            m_valid_n, m_abort_n;
    logic [DW:0]     exp_q[$];
    logic [N-1:0]    prev_grant, last_src_grant;

    int              s_len[N];
    int              s_pos[N];
    logic            s_act[N];
    logic [DW-1:0]   s_word[N][4];

    function automatic int rr_first(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_sources(input int p_new, input int p_drop, input int fixed_len);
        for (int i = 0; i < N; i++) begin
            if (!s_act[i] && $urandom_range(0, 99) < p_new) begin
                s_act[i] = 1'b1;
                s_pos[i] = 0;
                s_len[i] = (fixed_len > 0) ? fixed_len : $urandom_range(1, 4);
                for (int w = 0; w < 4; w++) s_word[i][w] = DW'($urandom);
            end else if (s_act[i] && $urandom_range(0, 99) < p_drop) begin
                s_act[i] = 1'b0;
            end
            req[i]                = s_act[i];
            data_in[i*DW +: DW]   = s_word[i][s_pos[i]];
            last_in[i]            = s_act[i] && (s_pos[i] == s_len[i] - 1);
        end
    endtask

    task automatic model_cycle(input bit check_alt);
        logic [N-1:0] e_grant, e_ack;
        logic         e_busy;
        logic [DW:0]  w;
        e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_ack   = (m_owner >= 0 && cyc >= m_next_slot && out_rdy && req[m_owner]) ? e_grant : '0;
        e_busy  = (m_owner >= 0) || (cyc < m_free_at);
        chk("model_grant", grant, e_grant);
        chk("model_ack", ack, e_ack);
        chk("model_busy", busy, e_busy);
        chk("model_valid", out_valid, m_valid_n);
        chk("model_abort", out_abort, m_abort_n);
        if (m_valid_n && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("model_word", {out_last, out_data}, w);
        end
        if (check_alt && grant != '0 && prev_grant == '0) begin
            if (last_src_grant != '0)
                chk("rr_alternate", grant, (last_src_grant == 2'b01) ? 2'b10 : 2'b01);
            last_src_grant = grant;
        end
        prev_grant = grant;

        m_valid_n = 1'b0;
        m_abort_n = 1'b0;
        if (m_owner >= 0) begin
            if (e_ack != '0) begin
                exp_q.push_back({last_in[m_owner], data_in[m_owner*DW +: DW]});
                m_valid_n   = 1'b1;
                m_next_slot = cyc + WP;
            end else if (!req[m_owner]) begin
                m_abort_n = 1'b1;
            end
            if ((e_ack != '0 && last_in[m_owner]) || m_abort_n) begin
                m_ptr     = (m_owner + 1) % N;
                m_owner   = -1;
                m_free_at = cyc + 1 + IFG;
            end
        end else if (cyc >= m_free_at && req != '0) begin
            m_owner     = rr_first(req, m_ptr);
            m_next_slot = cyc + 1;
        end
        for (int i = 0; i < N; i++) begin
            if (e_ack[i]) begin
                if (s_pos[i] == s_len[i] - 1) s_act[i] = 1'b0;
                else s_pos[i]++;
            end
        end
        cyc++;
    endtask

    task automatic run_model(input int n_cycles, input int p_new, input int p_drop,
                             input int p_rdy, input int fixed_len, input bit check_alt);
        reset_dut();
        cyc = 0; m_owner = -1; m_ptr = 0; m_free_at = 0; m_next_slot = 0;
        m_valid_n = 1'b0; m_abort_n = 1'b0;
        exp_q.delete();
        prev_grant = '0; last_src_grant = '0;
        for (int i = 0; i < N; i++) begin
            s_act[i] = 1'b0; s_pos[i] = 0; s_len[i] = 1;
            for (int w = 0; w < 4; w++) s_word[i][w] = '0;
        end
        for (int c = 0; c < n_cycles; c++) begin
            drive_sources(p_new, p_drop, fixed_len);
            out_rdy = ($urandom_range(0, 99) < p_rdy);
            #1;
            model_cycle(check_alt);
            @(negedge clk);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int   gc;
        int   ab;
        logic any_ack;

        // Single source 0, 3-word frame, out_rdy=1: words every WP cycles, then IFG gap.
        vecs[0]  = '{2'b01, 8'hA0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 8'hA0, 2'b00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{2'b01, 8'hA1, 2'b00, 1'b1, 2'b01, 2'b00, 1'b1, 8'hA0, 1'b0, 1'b1};
        vecs[3]  = '{2'b01, 8'hA1, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{2'b01, 8'hA1, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{2'b01, 8'hA1, 2'b00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{2'b01, 8'hA2, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 8'hA1, 1'b0, 1'b1};
        vecs[7]  = '{2'b01, 8'hA2, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{2'b01, 8'hA2, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[9]  = '{2'b01, 8'hA2, 2'b01, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{2'b00, 8'h00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 8'hA2, 1'b1, 1'b1};
        for (int r = 11; r <= 15; r++)
            vecs[r] = '{2'b00, 8'h00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[16] = '{2'b00, 8'h00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};

        reset_dut();
        for (int r = 0; r < 17; r++) begin
            req     = vecs[r].req;
            data_in = {8'h00, vecs[r].d0};
            last_in = vecs[r].last;
            out_rdy = vecs[r].rdy;
            #1;
            chk($sformatf("vec%0d_grant", r), grant, vecs[r].e_grant);
            chk($sformatf("vec%0d_ack", r), ack, vecs[r].e_ack);
            chk($sformatf("vec%0d_valid", r), out_valid, vecs[r].e_valid);
            chk($sformatf("vec%0d_busy", r), busy, vecs[r].e_busy);
            chk($sformatf("vec%0d_abort", r), out_abort, 0);
            if (vecs[r].e_valid) begin
                chk($sformatf("vec%0d_data", r), out_data, vecs[r].e_data);
                chk($sformatf("vec%0d_last", r), out_last, vecs[r].e_last);
            end
            @(negedge clk);
        end

        // Stall: out_rdy low for 10 cycles at a tick, then released.
        reset_dut();
        req = 2'b01; data_in = {8'h00, 8'h55}; last_in = 2'b00; out_rdy = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            #1;
            chk("stall_no_ack", ack, 0);
            chk("stall_no_valid", out_valid, 0);
            @(negedge clk);
        end
        out_rdy = 1'b1;
        #1;
        chk("stall_release_ack", ack, 2'b01);
        @(negedge clk);
        data_in = {8'h00, 8'h66}; last_in = 2'b01;
        #1;
        chk("stall_word1_valid", out_valid, 1);
        chk("stall_word1_data", out_data, 8'h55);
        for (int c = 13; c <= 15; c++) begin
            @(negedge clk);
            #1;
            chk("stall_word2_ack", ack, (c == 15) ? 2'b01 : 2'b00);
            chk("stall_no_dup", out_valid, 0);
        end
        @(negedge clk);
        req = 2'b00; last_in = 2'b00;
        #1;
        chk("stall_word2_valid", out_valid, 1);
        chk("stall_word2_data", out_data, 8'h66);
        chk("stall_word2_last", out_last, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("stall_after_valid", out_valid, 0);
        end

        // Abort: source 1 drops req after word 1 of 4; source 0 follows after the gap.
        @(negedge clk);
        reset_dut();
        req = 2'b10; data_in = {8'h11, 8'h00}; last_in = 2'b00; out_rdy = 1'b1;
        #1;
        chk("abort_c0_grant", grant, 0);
        @(negedge clk);
        #1;
        chk("abort_c1_grant", grant, 2'b10);
        chk("abort_c1_ack", ack, 2'b10);
        @(negedge clk);
        req = 2'b01; data_in = {8'h22, 8'hAA}; last_in = 2'b01;
        #1;
        chk("abort_c2_valid", out_valid, 1);
        chk("abort_c2_data", out_data, 8'h11);
        chk("abort_c2_ack", ack, 0);
        @(negedge clk);
        #1;
        chk("abort_pulse", out_abort, 1);
        chk("abort_pulse_novalid", out_valid, 0);
        chk("abort_grant_clear", grant, 0);
        chk("abort_busy_gap", busy, 1);
        gc = -1;
        for (int c = 4; c <= 24; c++) begin
            @(negedge clk);
            #1;
            if (c == 4) chk("abort_single_pulse", out_abort, 0);
            if (grant != '0) begin
                gc = c;
                break;
            end
        end
        chk("abort_regrant_cycle", gc, 10);
        chk("abort_regrant_src", grant, 2'b01);
        chk("abort_regrant_ack", ack, 2'b01);
        @(negedge clk);
        req = 2'b00; last_in = 2'b00;
        #1;
        chk("abort_src0_data", out_data, 8'hAA);
        chk("abort_src0_last", out_last, 1);

        // Reset in the middle of a frame restores pointer and clears outputs.
        @(negedge clk);
        reset_dut();
        req = 2'b01; last_in = 2'b01; data_in = {8'h00, 8'h10}; out_rdy = 1'b1;
        wait_ack(2'b01, 20, "rst_pre_ack0");
        @(negedge clk);
        req = 2'b10; last_in = 2'b00; data_in = {8'hB0, 8'h00};
        wait_ack(2'b10, 40, "rst_word1_ack");
        @(negedge clk);
        data_in = {8'hB1, 8'h00};
        wait_ack(2'b10, 20, "rst_word2_ack");
        @(negedge clk);
        rst = 1'b1;
        data_in = {8'hB2, 8'h00};
        @(negedge clk);
        #1;
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_last", out_last, 0);
        chk("rst_mid_abort", out_abort, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ack", ack, 0);
        rst = 1'b0;
        req = 2'b11; last_in = 2'b11;
        @(negedge clk);
        #1;
        chk("rst_first_grant_src0", grant, 2'b01);

        // Long stall with out_rdy held low.
        @(negedge clk);
        reset_dut();
        req = 2'b01; data_in = {8'h00, 8'h77}; last_in = 2'b00; out_rdy = 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
        ab = -1;
        for (int c = 0; c <= 40; c++) begin
            #1;
            if (out_abort && ab < 0) ab = c;
            @(negedge clk);
        end
        chk("wd_abort_cycle", ab, 18);
`else
        any_ack = 1'b0;
        ab = 0;
        for (int c = 0; c < 1000; c++) begin
            #1;
            if (ack != '0) any_ack = 1'b1;
            if (out_abort) ab++;
            @(negedge clk);
        end
        #1;
        chk("nowd_busy", busy, 1);
        chk("nowd_grant", grant, 2'b01);
        chk("nowd_no_ack", any_ack, 0);
        chk("nowd_no_abort", ab, 0);
`endif

        // Both sources always pending with 2-word frames: grants must alternate.
        @(negedge clk);
        run_model(300, 100, 0, 100, 2, 1'b1);

        // Randomized traffic: arrivals, drops, back-pressure.
        run_model(3000, 30, 2, 70, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
